up_sampler: RTL and testbench

Consumes the 8-bit blurred pixel stream from the Gaussian stage's output FIFO and produces a 2x up-sampled image by pixel replication. Each input pixel is emitted twice horizontally, and each input row is emitted twice vertically by replaying it from an internal line buffer. Sits between the Gaussian wrapper FIFO (upstream) and the difference/compare stage (downstream), with a ready/valid output handshake.

---
 rtl/up_sampler_pkg.sv | 33 +++
 rtl/up_sampler_if.sv | 32 +++
 rtl/up_line_buffer.sv | 37 +++
 rtl/up_sampler.sv | 183 ++++++++++++++++++
 tb/tb_up_sampler.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/up_sampler_pkg.sv
//------------------------------------------------------------------------------
// up_sampler_pkg : shared types and constants for the 2x pixel up-sampler
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package up_sampler_pkg;

    localparam int DATA_W        = 8;
    localparam int IN_WIDTH_DEF  = 400;
    localparam int IN_HEIGHT_DEF = 300;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W_DEF = cnt_w(IN_WIDTH_DEF);
    localparam int ROW_W_DEF = cnt_w(IN_HEIGHT_DEF);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_EMIT0  = 3'd2,
        S_EMIT1  = 3'd3,
        S_RPT_RD = 3'd4,
        S_RPT0   = 3'd5,
        S_RPT1   = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/up_sampler_if.sv
//------------------------------------------------------------------------------
// up_sampler_if : upstream FIFO read port plus downstream ready/valid stream
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface up_sampler_if;
    import up_sampler_pkg::*;

    logic              empty;
    logic              valid;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              valid_out;
    logic              ready;
    logic              line_end;
    logic              frame_end;

    modport master (
        input  empty, valid, din, ready,
        output rd_en, dout, valid_out, line_end, frame_end
    );

    modport slave (
        output empty, valid, din, ready,
        input  rd_en, dout, valid_out, line_end, frame_end
    );

endinterface

`default_nettype wire

// File: rtl/up_line_buffer.sv
//------------------------------------------------------------------------------
// up_line_buffer : single-port row store, synchronous read with 1-cycle latency
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module up_line_buffer
    import up_sampler_pkg::*;
#(
    parameter int DEPTH  = IN_WIDTH_DEF,
    parameter int ADDR_W = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read data register only changes on a read, so it holds through stalls.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/up_sampler.sv
//------------------------------------------------------------------------------
// up_sampler : 2x pixel-replicating up-sampler; UP_SAMPLER_FRAME_CNT_EN adds frame_cnt_o
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module up_sampler
    import up_sampler_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int IN_HEIGHT = IN_HEIGHT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    up_sampler_if.master bus,
    output logic         err_o
`ifdef UP_SAMPLER_FRAME_CNT_EN
    ,
    output logic [15:0]  frame_cnt_o
`endif
);

    localparam int COL_W = cnt_w(IN_WIDTH);
    localparam int ROW_W = cnt_w(IN_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_HEIGHT - 1);

    state_e            state_q;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              pend_q;
    logic              rd_en_q;
    logic              valid_out_q;
    logic              line_end_q;
    logic              frame_end_q;
    logic              rpt_sel_q;
    logic              err_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] w_rb_rdata;
    logic              w_accept;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_rb_we;
    logic              w_rb_re;

    assign w_accept   = valid_out_q & bus.ready;
    assign w_col_last = (col_q == COL_LAST);
    assign w_row_last = (row_q == ROW_LAST);
    assign col_d      = w_col_last ? '0 : col_q + 1'b1;
    assign row_d      = w_row_last ? '0 : row_q + 1'b1;
    assign w_rb_we    = (state_q == S_READ) & pend_q & bus.valid;
    assign w_rb_re    = (state_q == S_RPT_RD);

    up_line_buffer #(
        .DEPTH  (IN_WIDTH),
        .ADDR_W (COL_W)
    ) u_line_buffer (
        .clk     (clk),
        .we_i    (w_rb_we),
        .re_i    (w_rb_re),
        .addr_i  (col_q),
        .wdata_i (bus.din),
        .rdata_o (w_rb_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            pend_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            valid_out_q <= 1'b0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
            rpt_sel_q   <= 1'b0;
            err_q       <= 1'b0;
            hold_q      <= '0;
        end else begin
            rd_en_q <= 1'b0;
            if (bus.valid && !pend_q) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (!bus.empty) begin
                        rd_en_q <= 1'b1;
                        pend_q  <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (pend_q) begin
                        if (bus.valid) begin
                            hold_q      <= bus.din;
                            pend_q      <= 1'b0;
                            rpt_sel_q   <= 1'b0;
                            valid_out_q <= 1'b1;
                            state_q     <= S_EMIT0;
                        end
                    end else if (!bus.empty) begin
                        rd_en_q <= 1'b1;
                        pend_q  <= 1'b1;
                    end
                end
                S_EMIT0: begin
                    if (w_accept) begin
                        line_end_q <= w_col_last;
                        state_q    <= S_EMIT1;
                    end
                end
                S_EMIT1: begin
                    if (w_accept) begin
                        valid_out_q <= 1'b0;
                        line_end_q  <= 1'b0;
                        col_q       <= col_d;
                        if (w_col_last) begin
                            state_q <= S_RPT_RD;
                        end else begin
                            state_q <= S_READ;
                            // Request the next pixel on the accept edge to keep 4 cycles/pixel.
                            if (!bus.empty) begin
                                rd_en_q <= 1'b1;
                                pend_q  <= 1'b1;
                            end
                        end
                    end
                end
                S_RPT_RD: begin
                    rpt_sel_q   <= 1'b1;
                    valid_out_q <= 1'b1;
                    state_q     <= S_RPT0;
                end
                S_RPT0: begin
                    if (w_accept) begin
                        line_end_q  <= w_col_last;
                        frame_end_q <= w_col_last & w_row_last;
                        state_q     <= S_RPT1;
                    end
                end
                S_RPT1: begin
                    if (w_accept) begin
                        valid_out_q <= 1'b0;
                        line_end_q  <= 1'b0;
                        frame_end_q <= 1'b0;
                        col_q       <= col_d;
                        if (w_col_last) begin
                            row_q   <= row_d;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_RPT_RD;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.dout      = rpt_sel_q ? w_rb_rdata : hold_q;
    assign bus.valid_out = valid_out_q;
    assign bus.line_end  = line_end_q;
    assign bus.frame_end = frame_end_q;
    assign err_o         = err_q;

`ifdef UP_SAMPLER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (w_accept && frame_end_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_up_sampler.sv
//------------------------------------------------------------------------------
// tb_up_sampler : scoreboard bench for up_sampler at 4x2 input frames
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_up_sampler;

    localparam int W = 4;
    localparam int H = 2;

    typedef struct {
        logic [7:0] d;
        logic       le;
        logic       fe;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic err;
    int   checks = 0;
    int   errors = 0;

    exp_t exp_q[$];

    logic [7:0] fifo_mem [64];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_din = 8'h00;
    logic       inj_valid = 1'b0;
    logic       rnd_mode = 1'b0;

    logic       prev_stall = 1'b0;
    logic [7:0] prev_dout;
    logic       prev_le;
    logic       prev_fe;

`ifdef UP_SAMPLER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    int          exp_fc = 0;
    logic        fc_pending = 1'b0;
`endif

    up_sampler_if bus ();

    up_sampler #(
        .IN_WIDTH  (W),
        .IN_HEIGHT (H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.master),
        .err_o       (err)
`ifdef UP_SAMPLER_FRAME_CNT_EN
        ,
        .frame_cnt_o (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign bus.empty = (rd_ptr == wr_ptr);
    assign bus.valid = m_valid | inj_valid;
    assign bus.din   = inj_valid ? 8'hEE : m_din;

    // Upstream FIFO: data and valid one cycle after rd_en.
    always @(posedge clk) begin
        m_valid <= 1'b0;
        if (bus.rd_en && (rd_ptr != wr_ptr)) begin
            m_din   <= fifo_mem[rd_ptr[5:0]];
            rd_ptr  <= rd_ptr + 1;
            m_valid <= 1'b1;
        end
    end

    initial begin
        bus.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Output monitor: scoreboard pop on accept, hold checks on stall.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
`ifdef UP_SAMPLER_FRAME_CNT_EN
            exp_fc     = 0;
            fc_pending = 1'b0;
`endif
        end else begin
            if (prev_stall) begin
                check("hold_dout", 32'(bus.dout), 32'(prev_dout));
                check("hold_valid", 32'(bus.valid_out), 32'd1);
                check("hold_line_end", 32'(bus.line_end), 32'(prev_le));
                check("hold_frame_end", 32'(bus.frame_end), 32'(prev_fe));
            end
`ifdef UP_SAMPLER_FRAME_CNT_EN
            if (fc_pending) begin
                check("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
                fc_pending = 1'b0;
            end
`endif
            if (bus.valid_out && !bus.ready) begin
                check("rd_en_stall", 32'(bus.rd_en), 32'd0);
            end
            if (bus.valid_out && bus.ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", 32'(bus.dout), 32'(e.d));
                    check("line_end", 32'(bus.line_end), 32'(e.le));
                    check("frame_end", 32'(bus.frame_end), 32'(e.fe));
`ifdef UP_SAMPLER_FRAME_CNT_EN
                    if (e.fe) begin
                        exp_fc++;
                        fc_pending = 1'b1;
                    end
`endif
                end
            end
            prev_stall = bus.valid_out & ~bus.ready;
            prev_dout  = bus.dout;
            prev_le    = bus.line_end;
            prev_fe    = bus.frame_end;
        end
    end

    task automatic push_pix(input int v);
        fifo_mem[wr_ptr[5:0]] = 8'(v);
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_exp(input int v, input logic le, input logic fe);
        exp_t e;
        e.d  = 8'(v);
        e.le = le;
        e.fe = fe;
        exp_q.push_back(e);
    endtask

    task automatic push_exp_frame(input int base);
        for (int r = 0; r < H; r++)
            for (int p = 0; p < 2; p++)
                for (int c = 0; c < W; c++)
                    for (int k = 0; k < 2; k++)
                        push_exp(base + r * W + c, (c == W - 1) && (k == 1),
                                 (c == W - 1) && (k == 1) && (r == H - 1) && (p == 1));
    endtask

    task automatic push_frame(input int base);
        push_exp_frame(base);
        for (int i = 0; i < W * H; i++) push_pix(base + i);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_size(input string tag, input int n);
        for (int i = 0; i < 3000 && exp_q.size() != n; i++) begin
            @(posedge clk);
            #2;
        end
        check(tag, 32'(exp_q.size()), 32'(n));
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rd_en", 32'(bus.rd_en), 32'd0);
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_line_end", 32'(bus.line_end), 32'd0);
        check("rst_frame_end", 32'(bus.frame_end), 32'd0);
        check("rst_err", 32'(err), 32'd0);
`ifdef UP_SAMPLER_FRAME_CNT_EN
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame with ready held high
        push_frame(1);
        wait_drain("drain_basic");

        // Same frame with random backpressure
        rnd_mode = 1'b1;
        push_frame(1);
        wait_drain("drain_backpressure");
        rnd_mode = 1'b0;
        repeat (2) @(negedge clk);

        // Empty gap after pixel 2, with an unsolicited valid inside it
        push_exp_frame(1);
        push_pix(1);
        push_pix(2);
        wait_size("reach_gap", W * H * 4 - 4);
        check("err_before", 32'(err), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("gap_rd_en", 32'(bus.rd_en), 32'd0);
            check("gap_valid_out", 32'(bus.valid_out), 32'd0);
        end
        @(posedge clk);
        #1 inj_valid = 1'b1;
        @(posedge clk);
        #1 inj_valid = 1'b0;
        @(negedge clk);
        check("err_set", 32'(err), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("gap_rd_en", 32'(bus.rd_en), 32'd0);
            check("gap_valid_out", 32'(bus.valid_out), 32'd0);
        end
        for (int i = 3; i <= 8; i++) push_pix(i);
        wait_drain("drain_gap");
        check("err_sticky", 32'(err), 32'd1);

        // Reset in the middle of the row-0 replay
        for (int c = 0; c < W; c++) begin
            push_exp(1 + c, 1'b0, 1'b0);
            push_exp(1 + c, c == W - 1, 1'b0);
            push_pix(1 + c);
        end
        push_exp(1, 1'b0, 1'b0);
        push_exp(1, 1'b0, 1'b0);
        wait_size("reach_replay", 0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("inrst_dout", 32'(bus.dout), 32'd0);
            check("inrst_valid_out", 32'(bus.valid_out), 32'd0);
            check("inrst_rd_en", 32'(bus.rd_en), 32'd0);
            check("inrst_line_end", 32'(bus.line_end), 32'd0);
            check("inrst_frame_end", 32'(bus.frame_end), 32'd0);
            check("inrst_err", 32'(err), 32'd0);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Restart after reset, then two more frames
        push_frame(9);
        wait_drain("drain_after_reset");
        push_frame(17);
        wait_drain("drain_frame2");
        push_frame(25);
        wait_drain("drain_frame3");
`ifdef UP_SAMPLER_FRAME_CNT_EN
        check("frame_cnt_final", 32'(frame_cnt), 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
